// File: rtl/fetch_res_queue_if.sv
// Fetch-result queue bus: fetch-side inputs, decode-side handshake and status.
// master = the fetch/decode environment, slave = fetch_res_queue.
// Fetch side : io_i_fetch_valid, io_i_pc, io_i_fetch_res, io_i_flush,
//              io_i_branch_predict_pack_*, io_i_branch_presolve_pack_*,
//              io_o_fetch_ready
// Decode side: io_o_fetch_pack_valid, io_i_fetch_pack_ready,
//              io_o_fetch_pack_bits_*, io_o_count
// Optional   : io_o_perf_*_cnt when FETCH_RES_QUEUE_PERF_EN is defined.
interface fetch_res_queue_if #(
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned XLEN        = 64
);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned LINE_W = 32 * FETCH_WIDTH;

    logic                   io_i_fetch_valid;
    logic [XLEN-1:0]        io_i_pc;
    logic [LINE_W-1:0]      io_i_fetch_res;
    logic                   io_i_flush;
    logic                   io_i_branch_predict_pack_valid;
    logic [XLEN-1:0]        io_i_branch_predict_pack_target;
    logic [3:0]             io_i_branch_predict_pack_branch_type;
    logic                   io_i_branch_predict_pack_select;
    logic                   io_i_branch_predict_pack_taken;
    logic                   io_i_branch_presolve_pack_valid;
    logic                   io_i_branch_presolve_pack_taken;
    logic                   io_o_fetch_ready;

    logic                   io_o_fetch_pack_valid;
    logic                   io_i_fetch_pack_ready;
    logic [FETCH_WIDTH-1:0] io_o_fetch_pack_bits_valids;
    logic [XLEN-1:0]        io_o_fetch_pack_bits_pc;
    logic [LINE_W-1:0]      io_o_fetch_pack_bits_insts;
    logic                   io_o_fetch_pack_bits_branch_predict_pack_valid;
    logic [XLEN-1:0]        io_o_fetch_pack_bits_branch_predict_pack_target;
    logic [3:0]             io_o_fetch_pack_bits_branch_predict_pack_branch_type;
    logic                   io_o_fetch_pack_bits_branch_predict_pack_select;
    logic                   io_o_fetch_pack_bits_branch_predict_pack_taken;
    logic [CNT_W-1:0]       io_o_count;
`ifdef FETCH_RES_QUEUE_PERF_EN
    logic [31:0]            io_o_perf_enq_cnt;
    logic [31:0]            io_o_perf_kill_cnt;
    logic [31:0]            io_o_perf_full_cnt;
`endif

    modport master (
        output io_i_fetch_valid, io_i_pc, io_i_fetch_res, io_i_flush,
        output io_i_branch_predict_pack_valid, io_i_branch_predict_pack_target,
        output io_i_branch_predict_pack_branch_type, io_i_branch_predict_pack_select,
        output io_i_branch_predict_pack_taken,
        output io_i_branch_presolve_pack_valid, io_i_branch_presolve_pack_taken,
        output io_i_fetch_pack_ready,
        input  io_o_fetch_ready, io_o_fetch_pack_valid,
        input  io_o_fetch_pack_bits_valids, io_o_fetch_pack_bits_pc, io_o_fetch_pack_bits_insts,
        input  io_o_fetch_pack_bits_branch_predict_pack_valid,
        input  io_o_fetch_pack_bits_branch_predict_pack_target,
        input  io_o_fetch_pack_bits_branch_predict_pack_branch_type,
        input  io_o_fetch_pack_bits_branch_predict_pack_select,
        input  io_o_fetch_pack_bits_branch_predict_pack_taken,
        input  io_o_count
`ifdef FETCH_RES_QUEUE_PERF_EN
        ,
        input  io_o_perf_enq_cnt, io_o_perf_kill_cnt, io_o_perf_full_cnt
`endif
    );

    modport slave (
        input  io_i_fetch_valid, io_i_pc, io_i_fetch_res, io_i_flush,
        input  io_i_branch_predict_pack_valid, io_i_branch_predict_pack_target,
        input  io_i_branch_predict_pack_branch_type, io_i_branch_predict_pack_select,
        input  io_i_branch_predict_pack_taken,
        input  io_i_branch_presolve_pack_valid, io_i_branch_presolve_pack_taken,
        input  io_i_fetch_pack_ready,
        output io_o_fetch_ready, io_o_fetch_pack_valid,
        output io_o_fetch_pack_bits_valids, io_o_fetch_pack_bits_pc, io_o_fetch_pack_bits_insts,
        output io_o_fetch_pack_bits_branch_predict_pack_valid,
        output io_o_fetch_pack_bits_branch_predict_pack_target,
        output io_o_fetch_pack_bits_branch_predict_pack_branch_type,
        output io_o_fetch_pack_bits_branch_predict_pack_select,
        output io_o_fetch_pack_bits_branch_predict_pack_taken,
        output io_o_count
`ifdef FETCH_RES_QUEUE_PERF_EN
        ,
        output io_o_perf_enq_cnt, io_o_perf_kill_cnt, io_o_perf_full_cnt
`endif
    );
endinterface

// File: rtl/fetch_res_queue.sv
// Fetch-result queue: slices a fetch line into per-slot instructions, masks
// leading slots by PC offset, drops killed lines and buffers survivors in a
// DEPTH-entry FIFO feeding decode over a valid/ready handshake.
// Ports: clock, reset (async, active-high), bus (fetch_res_queue_if.slave).
// Optional: define FETCH_RES_QUEUE_PERF_EN for saturating perf counters.
module fetch_res_queue #(
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned XLEN        = 64
) (
    input  logic              clock,
    input  logic              reset,
    fetch_res_queue_if.slave  bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned OFF_W  = $clog2(FETCH_WIDTH);
    localparam int unsigned LINE_W = 32 * FETCH_WIDTH;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0] valids;
        logic [XLEN-1:0]        pc;
        logic [LINE_W-1:0]      insts;
        logic                   bp_valid;
        logic [XLEN-1:0]        bp_target;
        logic [3:0]             bp_type;
        logic                   bp_select;
        logic                   bp_taken;
    } entry_t;

    entry_t                 mem_q [DEPTH];
    entry_t                 wr_entry_d;
    entry_t                 head_c;
    logic [CNT_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_c;
    logic                   full_c;
    logic                   kill_c;
    logic                   enq_c;
    logic                   deq_c;
    logic                   pack_valid_c;
    logic [FETCH_WIDTH-1:0] slot_mask_c;
    logic                   unused_pc_c;

    // Byte offset bits are never needed.
    assign unused_pc_c = ^bus.io_i_pc[1:0];

    // Leading slots before the fetch PC's slot are not part of the packet.
    generate
        if (FETCH_WIDTH == 1) begin : g_mask_one
            assign slot_mask_c = '1;
        end else begin : g_mask_multi
            logic [OFF_W-1:0] off_c;
            assign off_c = bus.io_i_pc[OFF_W+1:2];
            always_comb begin
                slot_mask_c = '0;
                for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
                    slot_mask_c[i] = (32'(i) >= 32'(off_c));
                end
            end
        end
    endgenerate

    // Extra wrap bit in the pointers separates full from empty.
    assign count_c      = wr_ptr_q - rd_ptr_q;
    assign full_c       = (count_c == CNT_W'(DEPTH));
    assign kill_c       = bus.io_i_flush |
                          (bus.io_i_branch_presolve_pack_valid & bus.io_i_branch_presolve_pack_taken);
    assign enq_c        = bus.io_i_fetch_valid & ~full_c & ~kill_c;
    assign pack_valid_c = (count_c != '0) & ~bus.io_i_flush;
    assign deq_c        = pack_valid_c & bus.io_i_fetch_pack_ready;

    // Packet formed from the incoming line.
    always_comb begin
        wr_entry_d           = '0;
        wr_entry_d.valids    = slot_mask_c;
        wr_entry_d.pc        = {bus.io_i_pc[XLEN-1:OFF_W+2], (OFF_W+2)'(0)};
        wr_entry_d.insts     = bus.io_i_fetch_res;
        wr_entry_d.bp_valid  = bus.io_i_branch_predict_pack_valid;
        wr_entry_d.bp_target = bus.io_i_branch_predict_pack_target;
        wr_entry_d.bp_type   = bus.io_i_branch_predict_pack_branch_type;
        wr_entry_d.bp_select = bus.io_i_branch_predict_pack_select;
        wr_entry_d.bp_taken  = bus.io_i_branch_predict_pack_taken;
    end

    // Pointer update; flush empties the queue without touching storage.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (bus.io_i_flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (enq_c) wr_ptr_d = wr_ptr_q + CNT_W'(1);
            if (deq_c) rd_ptr_d = rd_ptr_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage clears on reset so the head reads zero out of reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (enq_c) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_entry_d;
        end
    end

    assign head_c = mem_q[rd_ptr_q[PTR_W-1:0]];

    assign bus.io_o_fetch_ready      = ~full_c;
    assign bus.io_o_fetch_pack_valid = pack_valid_c;
    assign bus.io_o_count            = count_c;
    assign bus.io_o_fetch_pack_bits_valids = head_c.valids;
    assign bus.io_o_fetch_pack_bits_pc     = head_c.pc;
    assign bus.io_o_fetch_pack_bits_insts  = head_c.insts;
    assign bus.io_o_fetch_pack_bits_branch_predict_pack_valid       = head_c.bp_valid;
    assign bus.io_o_fetch_pack_bits_branch_predict_pack_target      = head_c.bp_target;
    assign bus.io_o_fetch_pack_bits_branch_predict_pack_branch_type = head_c.bp_type;
    assign bus.io_o_fetch_pack_bits_branch_predict_pack_select      = head_c.bp_select;
    assign bus.io_o_fetch_pack_bits_branch_predict_pack_taken       = head_c.bp_taken;

`ifdef FETCH_RES_QUEUE_PERF_EN
    logic [31:0] perf_enq_q, perf_kill_q, perf_full_q;

    // Saturating event counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_enq_q  <= '0;
            perf_kill_q <= '0;
            perf_full_q <= '0;
        end else begin
            if (enq_c && (perf_enq_q != '1)) perf_enq_q <= perf_enq_q + 32'd1;
            if (bus.io_i_fetch_valid && kill_c && (perf_kill_q != '1))
                perf_kill_q <= perf_kill_q + 32'd1;
            if (bus.io_i_fetch_valid && full_c && (perf_full_q != '1))
                perf_full_q <= perf_full_q + 32'd1;
        end
    end

    assign bus.io_o_perf_enq_cnt  = perf_enq_q;
    assign bus.io_o_perf_kill_cnt = perf_kill_q;
    assign bus.io_o_perf_full_cnt = perf_full_q;
`endif

endmodule

// File: tb/tb_fetch_res_queue.sv
// Directed bench for fetch_res_queue (FETCH_WIDTH=2, DEPTH=4, XLEN=64) with a
// queue scoreboard of expected packets and an occupancy model.
module tb_fetch_res_queue;
    localparam int unsigned FW     = 2;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned XLEN   = 64;
    localparam int unsigned LINE_W = 32 * FW;

    typedef struct packed {
        logic [FW-1:0]     valids;
        logic [XLEN-1:0]   pc;
        logic [LINE_W-1:0] insts;
        logic [70:0]       bp;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    fetch_res_queue_if #(.FETCH_WIDTH(FW), .DEPTH(DEPTH), .XLEN(XLEN)) bus_if ();

    fetch_res_queue #(.FETCH_WIDTH(FW), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   mcount   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [63:0] pc, input logic [63:0] res);
        bus_if.io_i_fetch_valid                     = fv;
        bus_if.io_i_pc                              = pc;
        bus_if.io_i_fetch_res                       = res;
        bus_if.io_i_branch_predict_pack_valid       = 1'($urandom_range(0, 1));
        bus_if.io_i_branch_predict_pack_target      = {$urandom, $urandom};
        bus_if.io_i_branch_predict_pack_branch_type = 4'($urandom_range(0, 15));
        bus_if.io_i_branch_predict_pack_select      = 1'($urandom_range(0, 1));
        bus_if.io_i_branch_predict_pack_taken       = 1'($urandom_range(0, 1));
    endtask

    task automatic idle();
        bus_if.io_i_fetch_valid                = 1'b0;
        bus_if.io_i_flush                      = 1'b0;
        bus_if.io_i_branch_presolve_pack_valid = 1'b0;
        bus_if.io_i_branch_presolve_pack_taken = 1'b0;
    endtask

    // Expected packet built from the driven inputs.
    function automatic exp_t model_entry();
        exp_t e;
        logic [63:0] pc;
        int off;
        pc  = bus_if.io_i_pc;
        off = int'(pc[2]);
        for (int i = 0; i < int'(FW); i++) e.valids[i] = (i >= off);
        e.pc    = pc & ~64'h7;
        e.insts = bus_if.io_i_fetch_res;
        e.bp    = {bus_if.io_i_branch_predict_pack_valid, bus_if.io_i_branch_predict_pack_target,
                   bus_if.io_i_branch_predict_pack_branch_type, bus_if.io_i_branch_predict_pack_select,
                   bus_if.io_i_branch_predict_pack_taken};
        return e;
    endfunction

    // One clock: check handshake, pop/compare on deq, push on enq, check count.
    task automatic step(input string tag);
        logic kill, enq, deq, fl;
        exp_t e, n;
        #1;
        fl   = bus_if.io_i_flush;
        kill = fl | (bus_if.io_i_branch_presolve_pack_valid & bus_if.io_i_branch_presolve_pack_taken);
        enq  = bus_if.io_i_fetch_valid && (mcount != int'(DEPTH)) && !kill;
        deq  = (mcount != 0) && !fl && bus_if.io_i_fetch_pack_ready;
        check($sformatf("%s.fetch_ready", tag), 128'(bus_if.io_o_fetch_ready), 128'(mcount != int'(DEPTH)));
        check($sformatf("%s.pack_valid", tag), 128'(bus_if.io_o_fetch_pack_valid), 128'((mcount != 0) && !fl));
        if (deq) begin
            e = sb.pop_front();
            check($sformatf("%s.valids", tag), 128'(bus_if.io_o_fetch_pack_bits_valids), 128'(e.valids));
            check($sformatf("%s.pc", tag), 128'(bus_if.io_o_fetch_pack_bits_pc), 128'(e.pc));
            check($sformatf("%s.insts", tag), 128'(bus_if.io_o_fetch_pack_bits_insts), 128'(e.insts));
            check($sformatf("%s.bp", tag),
                  128'({bus_if.io_o_fetch_pack_bits_branch_predict_pack_valid,
                        bus_if.io_o_fetch_pack_bits_branch_predict_pack_target,
                        bus_if.io_o_fetch_pack_bits_branch_predict_pack_branch_type,
                        bus_if.io_o_fetch_pack_bits_branch_predict_pack_select,
                        bus_if.io_o_fetch_pack_bits_branch_predict_pack_taken}), 128'(e.bp));
        end
        n = model_entry();
        @(posedge clock);
        #1;
        if (fl) begin
            mcount = 0;
            sb.delete();
        end else begin
            mcount = mcount + (enq ? 1 : 0) - (deq ? 1 : 0);
        end
        if (enq) sb.push_back(n);
        check($sformatf("%s.count", tag), 128'(bus_if.io_o_count), 128'(mcount));
    endtask

    initial begin
        idle();
        bus_if.io_i_fetch_pack_ready = 1'b0;
        drive(1'b0, 64'h0, 64'h0);
        @(posedge clock);
        @(posedge clock);
        #1;
        // Reset state
        check("rst.count", 128'(bus_if.io_o_count), 128'(0));
        check("rst.pack_valid", 128'(bus_if.io_o_fetch_pack_valid), 128'(0));
        check("rst.fetch_ready", 128'(bus_if.io_o_fetch_ready), 128'(1));
        check("rst.valids", 128'(bus_if.io_o_fetch_pack_bits_valids), 128'(0));
        check("rst.pc", 128'(bus_if.io_o_fetch_pack_bits_pc), 128'(0));
        check("rst.insts", 128'(bus_if.io_o_fetch_pack_bits_insts), 128'(0));
        reset = 1'b0;

        // 1: offset slot masking and line alignment
        bus_if.io_i_fetch_pack_ready = 1'b1;
        drive(1'b1, 64'h0000_0000_8000_0004, 64'hBBBB_BBBB_AAAA_AAAA);
        step("t1.enq");
        idle();
        #1;
        check("t1.head_valid", 128'(bus_if.io_o_fetch_pack_valid), 128'(1));
        check("t1.head_valids", 128'(bus_if.io_o_fetch_pack_bits_valids), 128'(2'b10));
        check("t1.head_pc", 128'(bus_if.io_o_fetch_pack_bits_pc), 128'(64'h8000_0000));
        check("t1.head_slot1", 128'(bus_if.io_o_fetch_pack_bits_insts[63:32]), 128'(32'hBBBB_BBBB));
        step("t1.deq");
        step("t1.empty");

        // 2: fill to full under backpressure, 5th line refused, then drain
        bus_if.io_i_fetch_pack_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'h1000 + 64'(i * 4), {$urandom, $urandom});
            step($sformatf("t2.fill%0d", i));
        end
        idle();
        bus_if.io_i_fetch_pack_ready = 1'b1;
        for (int i = 0; i < 5; i++) step($sformatf("t2.drain%0d", i));

        // 3: steady enq+deq at count=2 across the pointer wrap
        bus_if.io_i_fetch_pack_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 64'h2000 + 64'(i * 8), {$urandom, $urandom});
            step($sformatf("t3.pre%0d", i));
        end
        bus_if.io_i_fetch_pack_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h3004 + 64'(i * 8), {$urandom, $urandom});
            step($sformatf("t3.both%0d", i));
        end
        idle();
        for (int i = 0; i < 3; i++) step($sformatf("t3.drain%0d", i));

        // 4: taken presolve kills the line; not-taken presolve does not
        bus_if.io_i_fetch_pack_ready = 1'b0;
        drive(1'b1, 64'h4000, {$urandom, $urandom});
        bus_if.io_i_branch_presolve_pack_valid = 1'b1;
        bus_if.io_i_branch_presolve_pack_taken = 1'b1;
        step("t4.taken");
        drive(1'b1, 64'h4004, {$urandom, $urandom});
        bus_if.io_i_branch_presolve_pack_taken = 1'b0;
        step("t4.not_taken");
        idle();
        bus_if.io_i_fetch_pack_ready = 1'b1;
        step("t4.drain");
        step("t4.empty");

        // 5: flush with a pending line at count=3
        bus_if.io_i_fetch_pack_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h5000 + 64'(i * 8), {$urandom, $urandom});
            step($sformatf("t5.fill%0d", i));
        end
        bus_if.io_i_fetch_pack_ready = 1'b1;
        drive(1'b1, 64'h5100, {$urandom, $urandom});
        bus_if.io_i_flush = 1'b1;
        step("t5.flush");
        idle();
        check("t5.after_ready", 128'(bus_if.io_o_fetch_ready), 128'(1));
        step("t5.after");

        // 6: asynchronous reset mid-burst at count=3
        bus_if.io_i_fetch_pack_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h6000 + 64'(i * 8), {$urandom, $urandom});
            step($sformatf("t6.fill%0d", i));
        end
        #1;
        reset = 1'b1;
        #1;
        check("t6.rst_count", 128'(bus_if.io_o_count), 128'(0));
        check("t6.rst_valid", 128'(bus_if.io_o_fetch_pack_valid), 128'(0));
        check("t6.rst_ready", 128'(bus_if.io_o_fetch_ready), 128'(1));
        mcount = 0;
        sb.delete();
        idle();
        @(posedge clock);
        #1;
        reset = 1'b0;
        bus_if.io_i_fetch_pack_ready = 1'b1;
        drive(1'b1, 64'h7004, {$urandom, $urandom});
        step("t6.recover_enq");
        idle();
        step("t6.recover_deq");
        step("t6.recover_empty");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/fetch_res_queue.md
Name: fetch_res_queue

Overview:
Parametrised fetch-result stage that replaces the combinational fetch-result packer. It slices a FETCH_WIDTH-wide fetch line into per-slot instructions and masks leading slots by PC offset. It drops lines killed by flush or a taken presolve, then buffers surviving packets in a DEPTH-entry FIFO. The FIFO drives decode through a valid/ready handshake. It sits between the I-cache response and decode and decouples fetch from decode backpressure.

Parameters:
FETCH_WIDTH, 2, instructions per fetch line; power of two, 1 to 8; each instruction is 32 bits.
DEPTH, 4, number of FIFO entries; power of two, at least 2.
XLEN, 64, PC and branch-target width.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high reset.
io_i_fetch_valid  in  1  fetch line present this cycle.
io_i_pc  in  XLEN  fetch PC; bits [log2(FETCH_WIDTH)+1:2] give the start slot.
io_i_fetch_res  in  32*FETCH_WIDTH  fetch line; slot i occupies bits [32i+31:32i].
io_i_flush  in  1  pipeline flush.
io_i_branch_predict_pack_valid/_target/_branch_type/_select/_taken  in  1/XLEN/4/1/1  predictor pack; stored with the packet.
io_i_branch_presolve_pack_valid, io_i_branch_presolve_pack_taken  in  1, 1  predecode redirect.
io_o_fetch_ready  out  1  FIFO not full; fetch may present a line.
io_o_fetch_pack_valid  out  1  head entry valid.
io_i_fetch_pack_ready  in  1  decode accepts the head entry.
io_o_fetch_pack_bits_valids  out  FETCH_WIDTH  per-slot valid mask of the head entry.
io_o_fetch_pack_bits_pc  out  XLEN  line-aligned PC of the head entry (low log2(FETCH_WIDTH)+2 bits forced to zero).
io_o_fetch_pack_bits_insts  out  32*FETCH_WIDTH  instructions of the head entry.
io_o_fetch_pack_bits_branch_predict_pack_*  out  same widths as inputs  predictor pack of the head entry.
io_o_count  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (asynchronous, active-high): pointers and count go to 0, and all storage clears to 0. All outputs read 0 except io_o_fetch_ready, which reads 1.
- Slot mask: off = io_i_pc[log2(FETCH_WIDTH)+1:2]; slot i is valid iff i >= off. With FETCH_WIDTH=1 the mask is constant 1.
- kill = io_i_flush | (io_i_branch_presolve_pack_valid & io_i_branch_presolve_pack_taken).
- enq = io_i_fetch_valid & io_o_fetch_ready & ~kill.
- A line with io_i_fetch_valid=1 while full is ignored; fetch must hold it.
- io_o_fetch_ready = (count != DEPTH). It is purely registered-state based, with no combinational path from io_i_fetch_pack_ready.
- deq = io_o_fetch_pack_valid & io_i_fetch_pack_ready.
- io_o_fetch_pack_valid = (count != 0) & ~io_i_flush.
- Latency: an entry enqueued at edge N is visible at the head in cycle N+1. There is no bypass, so an empty FIFO never presents same-cycle input.
- Simultaneous enq and deq: count is unchanged and both pointers advance. This is legal at any occupancy below full. At full, enq is blocked, so only deq occurs.
- Pointers wrap modulo DEPTH. count = wr_ptr - rd_ptr, with an extra wrap bit distinguishing full from empty.
- Flush: at the next edge count=0 and rd_ptr=wr_ptr. There is no enq that cycle, and deq is suppressed because valid is forced low. Storage is not cleared.
- Data outputs always read the entry at rd_ptr. When count=0 they are stale and the bench must not check them.
- Reset asserted mid-operation returns immediately to the reset state; any in-flight packet is lost.

Optional Feature:
FETCH_RES_QUEUE_PERF_EN:
- When defined, adds 32-bit saturating outputs io_o_perf_enq_cnt (enq events), io_o_perf_kill_cnt (io_i_fetch_valid & kill events) and io_o_perf_full_cnt (io_i_fetch_valid & full cycles). All three clear on reset and hold at 0xFFFFFFFF.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
1. FETCH_WIDTH=2, DEPTH=4: enqueue pc=0x8000_0004 with res=0xBBBB_BBBB_AAAA_AAAA, decode ready -> next cycle valid=1, valids=2'b10, pc=0x8000_0000, insts slot1=0xBBBBBBBB.
2. Decode ready held low, 5 consecutive lines -> count 1,2,3,4; fetch_ready=0 after the 4th; the 5th is not taken. Release ready -> 4 packets drain in order, 1 per cycle.
3. FIFO at count=2, enq and deq in the same cycle for 3 cycles -> count stays 2, order preserved across the pointer wrap.
4. Fetch line with presolve valid=1, taken=1 -> not enqueued, count unchanged. The same with taken=0 -> enqueued.
5. count=3 and flush asserted together with fetch_valid -> pack_valid=0 that cycle; next cycle count=0, fetch_ready=1, the line is not stored.
6. Assert reset asynchronously mid-burst at count=3 -> count=0, pack_valid=0, fetch_ready=1 before the next clock edge.
